byte_fifo4: RTL

BYTE_FIFO4 -- requirements
Module: byte_fifo4

---
 rtl/byte_fifo4.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/byte_fifo4.sv
// ---------------------------------------------------------------------------
// byte_fifo4 -- 4-entry x 8-bit first-word-fall-through FIFO
//
// Storage is four reg8 instances. Each one is written only when a push is
// accepted and the write pointer selects it. The head entry is presented
// combinationally on rdata. Overflow and underflow events are recorded in
// sticky flags that only reset can clear.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous, active-high reset
//   wdata  in   8  byte to enqueue
//   push   in   1  enqueue request
//   pop    in   1  dequeue request
//   rdata  out  8  head-of-queue byte, 8'h00 when empty
//   empty  out  1  count == 0
//   full   out  1  count == 4
//   count  out  3  number of valid entries (0..4)
//   ovf    out  1  sticky: a push was dropped while full
//   udf    out  1  sticky: a pop was dropped while empty
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// reg8 -- 8-bit register primitive with load enable
//
// Ports
//   clk  in   1  rising-edge clock
//   rst  in   1  asynchronous, active-high reset (clears to 8'h00)
//   en   in   1  load enable
//   d    in   8  data in
//   q    out  8  registered data
// ---------------------------------------------------------------------------
module reg8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= 8'h00;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

module byte_fifo4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wdata,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full,
    output logic [2:0] count,
    output logic       ovf,
    output logic       udf
);

    localparam int DEPTH = 4;

    logic [1:0] wptr_reg;
    logic [1:0] wptr_next;
    logic [1:0] rptr_reg;
    logic [1:0] rptr_next;
    logic [2:0] count_reg;
    logic [2:0] count_next;
    logic       ovf_reg;
    logic       ovf_next;
    logic       udf_reg;
    logic       udf_next;

    logic       push_ok;
    logic       pop_ok;
    logic       empty_int;
    logic       full_int;

    logic [DEPTH-1:0] entry_we;
    logic [7:0]       entry_q [DEPTH];

    // Flags come from the occupancy counter. With a power-of-two depth the
    // pointers are equal both when empty and when full, so they cannot tell
    // the two cases apart.
    assign empty_int = (count_reg == 3'd0);
    assign full_int  = (count_reg == 3'd4);

    // Acceptance is judged against the state before the edge. That is why a
    // push+pop on a full FIFO takes only the pop, and a push+pop on an empty
    // FIFO takes only the push.
    assign push_ok = push && !full_int;
    assign pop_ok  = pop && !empty_int;

    // Storage: one reg8 per slot, enabled only for the slot under wptr.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_we[gi] = push_ok && (wptr_reg == 2'(gi));

            reg8 u_reg8 (
                .clk (clk),
                .rst (rst),
                .en  (entry_we[gi]),
                .d   (wdata),
                .q   (entry_q[gi])
            );
        end
    endgenerate

    // Next-state logic. The 2-bit pointers wrap 3 -> 0 naturally.
    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        udf_next   = udf_reg;

        if (push_ok) begin
            wptr_next = wptr_reg + 2'd1;
        end
        if (pop_ok) begin
            rptr_next = rptr_reg + 2'd1;
        end

        // Net change is +1, -1 or 0. The acceptance gating keeps the result
        // inside 0..4.
        count_next = count_reg + {2'b00, push_ok} - {2'b00, pop_ok};

        if (push && !push_ok) begin
            ovf_next = 1'b1;
        end
        if (pop && !pop_ok) begin
            udf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg  <= 2'd0;
            rptr_reg  <= 2'd0;
            count_reg <= 3'd0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    // First-word-fall-through read. The output is forced to zero when empty
    // so that stale storage contents are never visible.
    assign rdata = empty_int ? 8'h00 : entry_q[rptr_reg];
    assign empty = empty_int;
    assign full  = full_int;
    assign count = count_reg;
    assign ovf   = ovf_reg;
    assign udf   = udf_reg;

endmodule
